// File: rtl/risc16_pkg.sv
// risc16_pkg -- shared encodings for the RiSC-16 single-cycle datapath.
//   Opcodes (instr[15:13]), ALU function codes, PC / regfile write-data mux
//   selects, and the ctrl_t bundle the decoder hands to the datapath.
package risc16_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_NAND  = 2'b01;
    localparam logic [1:0] ALU_PASS1 = 2'b10;
    localparam logic [1:0] ALU_EQ    = 2'b11;

    localparam logic [1:0] PC_INC    = 2'b00;  // PC+1
    localparam logic [1:0] PC_BRANCH = 2'b01;  // PC+1+simm7
    localparam logic [1:0] PC_ALU    = 2'b10;  // ALU result (JALR)

    localparam logic [1:0] TGT_ALU   = 2'b00;
    localparam logic [1:0] TGT_MEM   = 2'b01;
    localparam logic [1:0] TGT_PC    = 2'b10;  // link address PC+1

    typedef struct packed {
        logic [1:0] func_alu;
        logic       mux_alu1;
        logic       mux_alu2;
        logic [1:0] mux_pc;
        logic       mux_rf;
        logic [1:0] mux_tgt;
        logic       we_rf;
        logic       we_dmem;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// control_decode -- pure combinational opcode/eq -> ctrl_t decoder.
//   opcode  in  3   instr[15:13]
//   eq      in  1   ALU equality flag, only consulted for BEQ
//   ctrl    out     full control bundle, ungated write enables
// Every field starts at 0 so unused fields are never X; an unknown opcode
// falls into the default arm and produces all-zero controls (no latch).
module control_decode
    import risc16_pkg::*;
(
    input  logic [2:0] opcode,
    input  logic       eq,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_ADD: begin
                ctrl.func_alu = ALU_ADD;
                ctrl.we_rf    = 1'b1;
            end
            OP_ADDI: begin
                ctrl.func_alu = ALU_ADD;
                ctrl.mux_alu2 = 1'b1;
                ctrl.we_rf    = 1'b1;
            end
            OP_NAND: begin
                ctrl.func_alu = ALU_NAND;
                ctrl.we_rf    = 1'b1;
            end
            OP_LUI: begin
                ctrl.func_alu = ALU_PASS1;
                ctrl.mux_alu1 = 1'b1;
                ctrl.we_rf    = 1'b1;
            end
            OP_SW: begin
                // rA is the store data, so it goes out on the src2 port
                ctrl.func_alu = ALU_ADD;
                ctrl.mux_alu2 = 1'b1;
                ctrl.mux_rf   = 1'b1;
                ctrl.we_dmem  = 1'b1;
            end
            OP_LW: begin
                ctrl.func_alu = ALU_ADD;
                ctrl.mux_alu2 = 1'b1;
                ctrl.mux_tgt  = TGT_MEM;
                ctrl.we_rf    = 1'b1;
            end
            OP_BEQ: begin
                ctrl.func_alu = ALU_EQ;
                ctrl.mux_rf   = 1'b1;
                ctrl.mux_pc   = eq ? PC_BRANCH : PC_INC;
            end
            OP_JALR: begin
                ctrl.func_alu = ALU_PASS1;
                ctrl.mux_pc   = PC_ALU;
                ctrl.mux_tgt  = TGT_PC;
                ctrl.we_rf    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control.sv
// control -- RiSC-16 main decoder with write-enable arming.
//   clk, rst_n           clock (rising edge), async active-low reset
//   opcode[2:0], eq      instruction opcode and ALU equality flag
//   func_alu[1:0]        ALU function
//   mux_alu1, mux_alu2   ALU operand selects
//   mux_pc[1:0]          next-PC select
//   mux_rf               regfile src2 address select (rC / rA)
//   mux_tgt[1:0]         regfile write-data select
//   we_rf, we_dmem       write enables, held 0 in reset and for ARM_CYCLES
//                        clocks after reset release
// Build option: CONTROL_REG_OUT_EN registers all outputs (one-cycle latency,
// async-cleared to 0); otherwise decode is combinational.
module control
    import risc16_pkg::*;
#(
    parameter int ARM_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       eq,
    output logic [1:0] func_alu,
    output logic       mux_alu1,
    output logic       mux_alu2,
    output logic [1:0] mux_pc,
    output logic       mux_rf,
    output logic [1:0] mux_tgt,
    output logic       we_rf,
    output logic       we_dmem
);

    localparam int CNT_W = (ARM_CYCLES < 1) ? 1 : $clog2(ARM_CYCLES + 1);

    ctrl_t             dec;
    ctrl_t             gated;
    ctrl_t             ctrl_out;
    logic [CNT_W-1:0]  arm_cnt;
    logic              armed;

    control_decode u_decode (
        .opcode (opcode),
        .eq     (eq),
        .ctrl   (dec)
    );

    // Arming counter: counts clocks after release and parks at ARM_CYCLES.
    assign armed = (arm_cnt == CNT_W'(ARM_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            arm_cnt <= '0;
        else if (!armed)
            arm_cnt <= arm_cnt + 1'b1;
    end

    // rst_n in the gate makes the enables drop the instant reset asserts,
    // with no clock edge needed.
    always_comb begin
        gated         = dec;
        gated.we_rf   = dec.we_rf   & armed & rst_n;
        gated.we_dmem = dec.we_dmem & armed & rst_n;
    end

`ifdef CONTROL_REG_OUT_EN
    ctrl_t ctrl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ctrl_q <= '0;
        else
            ctrl_q <= gated;
    end

    assign ctrl_out = ctrl_q;
`else
    assign ctrl_out = gated;
`endif

    assign func_alu = ctrl_out.func_alu;
    assign mux_alu1 = ctrl_out.mux_alu1;
    assign mux_alu2 = ctrl_out.mux_alu2;
    assign mux_pc   = ctrl_out.mux_pc;
    assign mux_rf   = ctrl_out.mux_rf;
    assign mux_tgt  = ctrl_out.mux_tgt;
    assign we_rf    = ctrl_out.we_rf;
    assign we_dmem  = ctrl_out.we_dmem;

endmodule

// File: tb/tb_control.sv
// tb_control -- self-checking bench for control (ARM_CYCLES=1).
// Expected outputs come from the instruction table below plus a count of
// clock edges seen since reset release; with CONTROL_REG_OUT_EN the expected
// vector is captured at each clock edge instead of applied immediately.
module tb_control;

    localparam int ARM = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic       eq;
    logic [1:0] func_alu;
    logic       mux_alu1;
    logic       mux_alu2;
    logic [1:0] mux_pc;
    logic       mux_rf;
    logic [1:0] mux_tgt;
    logic       we_rf;
    logic       we_dmem;

    int errors = 0;
    int checks = 0;

    control #(.ARM_CYCLES(ARM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .eq       (eq),
        .func_alu (func_alu),
        .mux_alu1 (mux_alu1),
        .mux_alu2 (mux_alu2),
        .mux_pc   (mux_pc),
        .mux_rf   (mux_rf),
        .mux_tgt  (mux_tgt),
        .we_rf    (we_rf),
        .we_dmem  (we_dmem)
    );

    always #5 clk = ~clk;

    // Packed view: func(2) alu1 alu2 pc(2) rf tgt(2) we_rf we_dmem = 11 bits
    function automatic logic [10:0] table_row(input logic [2:0] op, input logic e);
        case (op)
            3'd0: return {2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0}; // ADD
            3'd1: return {2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0}; // ADDI
            3'd2: return {2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0}; // NAND
            3'd3: return {2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0}; // LUI
            3'd4: return {2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1}; // SW
            3'd5: return {2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0}; // LW
            3'd6: return {2'b11, 1'b0, 1'b0, (e ? 2'b01 : 2'b00), 1'b1, 2'b00, 1'b0, 1'b0}; // BEQ
            default: return {2'b10, 1'b0, 1'b0, 2'b10, 1'b0, 2'b10, 1'b1, 1'b0}; // JALR
        endcase
    endfunction

    function automatic logic [10:0] with_gate(input logic [10:0] row, input logic ok);
        logic [10:0] r;
        r = row;
        if (!ok) r[1:0] = 2'b00;
        return r;
    endfunction

    // Reference state: edges since release, and the registered-build image.
    int          edges = 0;
    logic [10:0] exp_q = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges = 0;
            exp_q = '0;
        end else begin
            exp_q = with_gate(table_row(opcode, eq), edges >= ARM);
            if (edges < 1000) edges++;
        end
    end

    function automatic logic [10:0] expected();
`ifdef CONTROL_REG_OUT_EN
        return exp_q;
`else
        return with_gate(table_row(opcode, eq), (rst_n === 1'b1) && (edges >= ARM));
`endif
    endfunction

    function automatic logic [10:0] observed();
        return {func_alu, mux_alu1, mux_alu2, mux_pc, mux_rf, mux_tgt, we_rf, we_dmem};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (op=%0d eq=%0b rst_n=%0b)",
                     tag, got, exp, opcode, eq, rst_n);
        end
    endtask

    // Drive on the falling edge, check just after driving and just after the
    // next rising edge.
    task automatic step(input string tag, input logic [2:0] op, input logic e);
        @(negedge clk);
        opcode = op;
        eq     = e;
        #1 chk({tag, "_pre"}, 32'(observed()), 32'(expected()));
        @(posedge clk);
        #1 chk({tag, "_post"}, 32'(observed()), 32'(expected()));
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 3'd4;  // SW held through reset
        eq     = 1'b0;

        // Reset: write enables off regardless of decode
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we_dmem", 32'(we_dmem), 32'd0);
        chk("rst_we_rf",   32'(we_rf),   32'd0);
        chk("rst_all",     32'(observed()), 32'(expected()));

        // Release with ARM_CYCLES=1: blocked across the first edge, live after
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arm_pre_edge1", 32'(observed()), 32'(expected()));
`ifndef CONTROL_REG_OUT_EN
        chk("arm_we_dmem_e1", 32'(we_dmem), 32'd0);
`endif
        @(posedge clk);
        #1 chk("arm_after_edge1", 32'(observed()), 32'(expected()));
        @(posedge clk);
        #1 chk("arm_after_edge2", 32'(observed()), 32'(expected()));
        chk("arm_we_dmem_on", 32'(we_dmem), 32'd1);

        // Full sweep of the table
        for (int op = 0; op < 8; op++)
            for (int e = 0; e < 2; e++)
                step($sformatf("sweep_op%0d_eq%0d", op, e), 3'(op), 1'(e));

        // BEQ both ways, JALR, LW spot checks
        step("beq_nt", 3'd6, 1'b0);
        step("beq_t",  3'd6, 1'b1);
        step("jalr",   3'd7, 1'b0);
`ifndef CONTROL_REG_OUT_EN
        chk("jalr_we_rf", 32'(we_rf), 32'd1);
`endif
        step("lw", 3'd5, 1'b1);

        // 000 -> 011: LUI's operand-1 select (one clock later when registered)
        step("lui_from_add0", 3'd0, 1'b0);
        step("lui_from_add1", 3'd3, 1'b0);

        // Random instruction stream
        for (int i = 0; i < 200; i++)
            step("rand", 3'($urandom_range(7)), 1'($urandom_range(1)));

        // Async reset mid-cycle with ADD: enables must drop with no clock edge
        step("pre_async", 3'd0, 1'b0);
        #3 rst_n = 1'b0;
        #1 chk("async_we_rf", 32'(we_rf), 32'd0);
        chk("async_all", 32'(observed()), 32'(expected()));

        // Re-arm after the async reset
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++)
            step("rearm", 3'($urandom_range(7)), 1'($urandom_range(1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
